ahb_lite_fir_slave: RTL and testbench

AHB-Lite slave front end of the FIR filter accelerator. It decodes bus transfers into a register file holding the sample, four coefficients and a new-coefficient-set flag. It drives the `data_ready` handshake into the filter controller and exposes filter status and result for readback. It sits directly upstream of the controller/datapath and the coefficient loader.

---
 rtl/ahb_lite_fir_slave_if.sv | 24 ++
 rtl/ahb_lite_fir_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_ahb_lite_fir_slave.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_fir_slave_if.sv
// AHB-Lite bus bundle between the bus master and the FIR filter slave.
// The master modport drives the address/control/write-data signals.
// The slave modport returns read data, hready and hresp.
interface ahb_lite_fir_slave_if;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_fir_slave.sv
// AHB-Lite slave front end of the FIR filter accelerator.
// The slave holds a register file with these entries:
//   - the sample register
//   - four coefficients
//   - the new-coefficient-set flag
// It drives data_ready to the controller and reads back status and result.
// Optional feature macro: AHB_FIR_ERR_RESP_EN.
//   - When defined, illegal accesses get a two-cycle ERROR response.
//   - An illegal access is a write to 0x0/0x2, or any hsize >= 2.
//   - When undefined, illegal writes are dropped.
//   - When undefined, illegal-size reads return the halfword.
module ahb_lite_fir_slave (
  input  logic                        clk,
  input  logic                        n_rst,
  ahb_lite_fir_slave_if.slave         bus,
  input  logic                        i_modwait,
  input  logic                        i_err,
  input  logic [15:0]                 i_fir_out,
  input  logic [1:0]                  i_coefficient_num,
  input  logic                        i_clear_new_coeff,
  output logic [15:0]                 o_sample_data,
  output logic [15:0]                 o_fir_coefficient,
  output logic                        o_data_ready,
  output logic                        o_new_coefficient_set
);

  // Merge write data into the old value, honouring byte lanes.
  function automatic logic [15:0] merge_lane(input logic [15:0] old_v,
                                             input logic [15:0] wdata,
                                             input logic        is_byte,
                                             input logic        hi_lane);
    if (!is_byte) begin
      merge_lane = wdata;
    end else if (hi_lane) begin
      merge_lane = {wdata[15:8], old_v[7:0]};
    end else begin
      merge_lane = {old_v[15:8], wdata[7:0]};
    end
  endfunction

  // Address-phase capture
  logic              r_valid;
  logic [3:0]        r_addr;
  logic [1:0]        r_size;
  logic              r_write;

  // Register file
  logic [15:0]       r_sample;
  logic [3:0][15:0]  r_coeff;
  logic              r_new_coeff;
  logic              r_data_ready;

  logic              w_active;
  logic              w_addr_accept;
  logic              w_addr_valid;
  logic              w_wr_ok;
  logic              w_is_byte;
  logic              w_sample_wr;
  logic              w_newc_wr;
  logic [2:0]        w_coef_off;
  logic [15:0]       w_newc_merged;
  logic [15:0]       w_rdata;
  logic [15:0]       w_coef_sel;
  logic [15:0]       w_status;

  assign w_active = bus.hsel && bus.htrans[1];

`ifdef AHB_FIR_ERR_RESP_EN
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

  err_state_t r_state;
  logic       r_hready;
  logic       r_hresp;
  logic       w_illegal;

  assign w_illegal = w_active &&
                     (bus.hsize[1] || (bus.hwrite && (bus.haddr[3:2] == 2'b00)));
  // A new address phase is only taken while the bus is not stalled in ERR1.
  assign w_addr_accept = r_hready;
  assign w_addr_valid  = w_active && !w_illegal;

  // Two-cycle ERROR response FSM with registered hready/hresp.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_OK;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      case (r_state)
        ST_OK, ST_ERR2: begin
          if (w_illegal) begin
            r_state  <= ST_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= 1'b1;
          end else begin
            r_state  <= ST_OK;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          r_state  <= ST_OK;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hready = r_hready;
  assign bus.hresp  = r_hresp;
`else
  assign w_addr_accept = 1'b1;
  assign w_addr_valid  = w_active;
  assign bus.hready    = 1'b1;
  assign bus.hresp     = 1'b0;
`endif

  // Capture the address phase; a stalled bus leaves no transfer pending.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid <= 1'b0;
      r_addr  <= 4'h0;
      r_size  <= 2'b00;
      r_write <= 1'b0;
    end else if (w_addr_accept) begin
      r_valid <= w_addr_valid;
      r_addr  <= bus.haddr;
      r_size  <= bus.hsize;
      r_write <= bus.hwrite;
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Only legal sizes to writable addresses commit; everything else is dropped.
  assign w_wr_ok       = r_valid && r_write && !r_size[1] && (r_addr[3:2] != 2'b00);
  assign w_is_byte     = (r_size == 2'b00);
  assign w_sample_wr   = w_wr_ok && (r_addr[3:1] == 3'd2);
  assign w_newc_wr     = w_wr_ok && (r_addr[3:1] == 3'd7);
  assign w_coef_off    = r_addr[3:1] - 3'd3;
  assign w_newc_merged = merge_lane({15'h0000, r_new_coeff}, bus.hwdata, w_is_byte, r_addr[0]);

  // Commit data-phase writes to the sample and coefficient registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sample <= 16'h0000;
      r_coeff  <= {4{16'h0000}};
    end else if (w_wr_ok) begin
      case (r_addr[3:1])
        3'd2:    r_sample <= merge_lane(r_sample, bus.hwdata, w_is_byte, r_addr[0]);
        3'd3, 3'd4, 3'd5, 3'd6:
                 r_coeff[w_coef_off[1:0]] <= merge_lane(r_coeff[w_coef_off[1:0]],
                                                         bus.hwdata, w_is_byte, r_addr[0]);
        default: r_sample <= r_sample;
      endcase
    end else begin
      r_sample <= r_sample;
    end
  end

  // Sample handshake: a sample write wins over the controller's clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_ready <= 1'b0;
    end else if (w_sample_wr) begin
      r_data_ready <= 1'b1;
    end else if (r_data_ready && i_modwait) begin
      r_data_ready <= 1'b0;
    end else begin
      r_data_ready <= r_data_ready;
    end
  end

  // New-coefficient-set flag: a bus write wins over the loader's clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_new_coeff <= 1'b0;
    end else if (w_newc_wr) begin
      r_new_coeff <= w_newc_merged[0];
    end else if (i_clear_new_coeff) begin
      r_new_coeff <= 1'b0;
    end else begin
      r_new_coeff <= r_new_coeff;
    end
  end

  assign w_status = {7'h00, i_err, 7'h00, (i_modwait | r_data_ready | r_new_coeff)};

  // Read mux: full halfword at the even address, zero outside a valid read.
  always_comb begin
    w_rdata = 16'h0000;
    if (r_valid && !r_write) begin
      case (r_addr[3:1])
        3'd0:    w_rdata = w_status;
        3'd1:    w_rdata = i_fir_out;
        3'd2:    w_rdata = r_sample;
        3'd3:    w_rdata = r_coeff[0];
        3'd4:    w_rdata = r_coeff[1];
        3'd5:    w_rdata = r_coeff[2];
        3'd6:    w_rdata = r_coeff[3];
        3'd7:    w_rdata = {15'h0000, r_new_coeff};
        default: w_rdata = 16'h0000;
      endcase
    end else begin
      w_rdata = 16'h0000;
    end
  end

  // Coefficient selected by the loader.
  always_comb begin
    w_coef_sel = 16'h0000;
    case (i_coefficient_num)
      2'd0:    w_coef_sel = r_coeff[0];
      2'd1:    w_coef_sel = r_coeff[1];
      2'd2:    w_coef_sel = r_coeff[2];
      2'd3:    w_coef_sel = r_coeff[3];
      default: w_coef_sel = 16'h0000;
    endcase
  end

  assign bus.hrdata            = w_rdata;
  assign o_sample_data         = r_sample;
  assign o_fir_coefficient     = w_coef_sel;
  assign o_data_ready          = r_data_ready;
  assign o_new_coefficient_set = r_new_coeff;

endmodule

// File: tb/tb_ahb_lite_fir_slave.sv
// Directed self-checking bench for ahb_lite_fir_slave.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_ahb_lite_fir_slave;

  logic        clk;
  logic        n_rst;
  logic        modwait;
  logic        err;
  logic [15:0] fir_out;
  logic [1:0]  coefficient_num;
  logic        clear_new_coeff;
  logic [15:0] sample_data;
  logic [15:0] fir_coefficient;
  logic        data_ready;
  logic        new_coefficient_set;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rd;

  ahb_lite_fir_slave_if ahb ();

  ahb_lite_fir_slave dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .bus                   (ahb),
    .i_modwait             (modwait),
    .i_err                 (err),
    .i_fir_out             (fir_out),
    .i_coefficient_num     (coefficient_num),
    .i_clear_new_coeff     (clear_new_coeff),
    .o_sample_data         (sample_data),
    .o_fir_coefficient     (fir_coefficient),
    .o_data_ready          (data_ready),
    .o_new_coefficient_set (new_coefficient_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_idle();
    ahb.hsel   = 1'b0;
    ahb.htrans = 2'd0;
    ahb.hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic [3:0] a, input logic [1:0] sz, input logic wr);
    ahb.hsel   = 1'b1;
    ahb.haddr  = a;
    ahb.htrans = 2'd2;
    ahb.hsize  = sz;
    ahb.hwrite = wr;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [1:0] sz, input logic [15:0] d);
    addr_phase(a, sz, 1'b1);
    @(posedge clk); @(negedge clk);
    bus_idle();
    ahb.hwdata = d;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [1:0] sz, output logic [15:0] d);
    addr_phase(a, sz, 1'b0);
    @(posedge clk); @(negedge clk);
    bus_idle();
    d = ahb.hrdata;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    n_rst           = 1'b0;
    modwait         = 1'b0;
    err             = 1'b0;
    fir_out         = 16'h0000;
    coefficient_num = 2'd0;
    clear_new_coeff = 1'b0;
    ahb.haddr       = 4'h0;
    ahb.hsize       = 2'd1;
    ahb.hwdata      = 16'h0000;
    bus_idle();
    repeat (3) @(negedge clk);

    // Reset state
    check_value("rst_hrdata", ahb.hrdata, 16'h0000);
    check_value("rst_hready", {15'h0000, ahb.hready}, 16'h0001);
    check_value("rst_hresp", {15'h0000, ahb.hresp}, 16'h0000);
    check_value("rst_data_ready", {15'h0000, data_ready}, 16'h0000);
    check_value("rst_new_coeff", {15'h0000, new_coefficient_set}, 16'h0000);
    check_value("rst_sample", sample_data, 16'h0000);
    n_rst   = 1'b1;
    fir_out = 16'h0F0F;
    @(negedge clk);

    // All registers read 0 after reset; result is live
    for (int i = 0; i < 8; i++) begin
      bus_read(4'(2 * i), 2'd1, rd);
      check_value($sformatf("rst_read_%0h", 2 * i), rd, (i == 1) ? 16'h0F0F : 16'h0000);
    end

    // Halfword sample write sets data_ready; status shows busy
    bus_write(4'h4, 2'd1, 16'h1234);
    check_value("sample_hw", sample_data, 16'h1234);
    check_value("dr_set", {15'h0000, data_ready}, 16'h0001);
    bus_read(4'h0, 2'd1, rd);
    check_value("status_busy_dr", rd, 16'h0001);
    modwait = 1'b1;
    @(posedge clk); @(negedge clk);
    check_value("dr_clear", {15'h0000, data_ready}, 16'h0000);
    bus_read(4'h0, 2'd1, rd);
    check_value("status_busy_mw", rd, 16'h0001);
    modwait = 1'b0;

    // A sample write on the clearing edge keeps data_ready high
    bus_write(4'h4, 2'd1, 16'h0042);
    check_value("dr_set2", {15'h0000, data_ready}, 16'h0001);
    addr_phase(4'h4, 2'd1, 1'b1);
    @(posedge clk); @(negedge clk);
    bus_idle();
    ahb.hwdata = 16'h0099;
    modwait    = 1'b1;
    @(posedge clk); @(negedge clk);
    check_value("dr_write_wins", {15'h0000, data_ready}, 16'h0001);
    check_value("sample_0099", sample_data, 16'h0099);
    @(posedge clk); @(negedge clk);
    check_value("dr_clear2", {15'h0000, data_ready}, 16'h0000);
    modwait = 1'b0;

    // Byte lanes into F0
    bus_write(4'h7, 2'd0, 16'hAB22);
    bus_write(4'h6, 2'd0, 16'h11CD);
    bus_read(4'h6, 2'd1, rd);
    check_value("f0_bytes", rd, 16'hABCD);
    bus_read(4'h7, 2'd1, rd);
    check_value("f0_odd_read", rd, 16'hABCD);
    coefficient_num = 2'd0;
    #1;
    check_value("fir_coef0", fir_coefficient, 16'hABCD);
    @(negedge clk);

    // Upper-byte write to the sample also raises data_ready
    bus_write(4'h5, 2'd0, 16'hEE00);
    check_value("sample_byte_hi", sample_data, 16'hEE99);
    check_value("dr_byte", {15'h0000, data_ready}, 16'h0001);
    modwait = 1'b1;
    @(posedge clk); @(negedge clk);
    modwait = 1'b0;
    check_value("dr_clear3", {15'h0000, data_ready}, 16'h0000);

    // Halfword write at an odd address ignores haddr[0]
    bus_write(4'h9, 2'd1, 16'h2468);
    bus_read(4'h8, 2'd1, rd);
    check_value("f1_hw_odd", rd, 16'h2468);

    // Back-to-back write then read of 0xC
    addr_phase(4'hC, 2'd1, 1'b1);
    @(posedge clk); @(negedge clk);
    ahb.hwdata = 16'h5555;
    addr_phase(4'hC, 2'd1, 1'b0);
    @(posedge clk); @(negedge clk);
    bus_idle();
    check_value("b2b_read", ahb.hrdata, 16'h5555);
    @(posedge clk); @(negedge clk);
    coefficient_num = 2'd3;
    #1;
    check_value("fir_coef3", fir_coefficient, 16'h5555);
    @(negedge clk);

    // New-coefficient-set: write wins over a simultaneous clear
    clear_new_coeff = 1'b1;
    bus_write(4'hE, 2'd1, 16'h0001);
    clear_new_coeff = 1'b0;
    check_value("nc_write_wins", {15'h0000, new_coefficient_set}, 16'h0001);
    bus_read(4'h0, 2'd1, rd);
    check_value("status_nc", rd, 16'h0001);
    clear_new_coeff = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_new_coeff = 1'b0;
    check_value("nc_cleared", {15'h0000, new_coefficient_set}, 16'h0000);
    bus_read(4'h0, 2'd1, rd);
    check_value("status_idle", rd, 16'h0000);
    err = 1'b1;
    bus_read(4'h0, 2'd1, rd);
    check_value("status_err", rd, 16'h0100);
    err = 1'b0;
    bus_write(4'hE, 2'd1, 16'hFFFF);
    bus_read(4'hE, 2'd1, rd);
    check_value("nc_read_bit0", rd, 16'h0001);
    bus_write(4'hE, 2'd1, 16'h0000);
    check_value("nc_write0", {15'h0000, new_coefficient_set}, 16'h0000);

    // Illegal write to the read-only result register
    fir_out = 16'h3C3C;
    addr_phase(4'h2, 2'd1, 1'b1);
    @(posedge clk); @(negedge clk);
    bus_idle();
    ahb.hwdata = 16'hFFFF;
`ifdef AHB_FIR_ERR_RESP_EN
    check_value("err1_hready", {15'h0000, ahb.hready}, 16'h0000);
    check_value("err1_hresp", {15'h0000, ahb.hresp}, 16'h0001);
    @(posedge clk); @(negedge clk);
    check_value("err2_hready", {15'h0000, ahb.hready}, 16'h0001);
    check_value("err2_hresp", {15'h0000, ahb.hresp}, 16'h0001);
`else
    check_value("ro_hready", {15'h0000, ahb.hready}, 16'h0001);
    check_value("ro_hresp", {15'h0000, ahb.hresp}, 16'h0000);
`endif
    @(posedge clk); @(negedge clk);
    bus_read(4'h2, 2'd1, rd);
    check_value("result_unchanged", rd, 16'h3C3C);

    // Illegal-size write is dropped; illegal-size read
    bus_write(4'h4, 2'd2, 16'hDEAD);
    check_value("bad_size_wr", sample_data, 16'hEE99);
    check_value("bad_size_dr", {15'h0000, data_ready}, 16'h0000);
    bus_read(4'h4, 2'd2, rd);
`ifdef AHB_FIR_ERR_RESP_EN
    check_value("bad_size_rd", rd, 16'h0000);
    @(negedge clk);
`else
    check_value("bad_size_rd", rd, 16'hEE99);
`endif

    // Reset in the data phase loses the pending write
    addr_phase(4'h8, 2'd1, 1'b1);
    @(posedge clk); @(negedge clk);
    bus_idle();
    ahb.hwdata = 16'h7777;
    n_rst      = 1'b0;
    @(posedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    bus_read(4'h8, 2'd1, rd);
    check_value("rst_mid_f1", rd, 16'h0000);
    check_value("rst_mid_sample", sample_data, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
